// File: rtl/playfield_renderer.sv
// playfield_renderer
//   On a start pulse, sweeps a column-major playfield held as a circular
//   column buffer in external synchronous RAM, then a rectangular sprite.
//   Emits one pixel per cycle on a vga_adapter-style x/y/colour/plot port.
// Ports:
//   clk, resetn (sync, active-low), start
//   col_head, sprite_x, sprite_y, sprite_colour : frame inputs, latched at start
//   col_rd, col_addr, col_data : column RAM interface (data one cycle after read)
//   x, y, colour, plot         : pixel output
//   busy, done                 : status (done is a one-cycle pulse)
module playfield_renderer #(
  parameter int unsigned   COLS  = 120,
  parameter int unsigned   ROWS  = 100,
  parameter int unsigned   X0    = 20,
  parameter int unsigned   Y0    = 10,
  parameter int unsigned   XW    = 8,
  parameter int unsigned   YW    = 7,
  parameter int unsigned   CW    = 3,
  parameter int unsigned   SPR_W = 4,
  parameter int unsigned   SPR_H = 6,
  parameter logic [CW-1:0] FG    = 3'b111,
  parameter logic [CW-1:0] BG    = 3'b000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [$clog2(COLS)-1:0]  col_head,
  input  logic [XW-1:0]            sprite_x,
  input  logic [YW-1:0]            sprite_y,
  input  logic [CW-1:0]            sprite_colour,
  output logic                     col_rd,
  output logic [$clog2(COLS)-1:0]  col_addr,
  input  logic [ROWS-1:0]          col_data,
  output logic [XW-1:0]            x,
  output logic [YW-1:0]            y,
  output logic [CW-1:0]            colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW  = $clog2(COLS);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned SXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned SYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_PLOT, S_SPRITE, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     c_q, c_d, head_q, head_d;
  logic [RW-1:0]     r_q, r_d;
  logic [SXW-1:0]    sx_q, sx_d;
  logic [SYW-1:0]    sy_q, sy_d;
  logic [XW-1:0]     spr_x_q, spr_x_d;
  logic [YW-1:0]     spr_y_q, spr_y_d;
  logic [CW-1:0]     spr_c_q, spr_c_d;
  logic [ROWS-1:0]   col_reg_q, col_reg_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [CW-1:0]     colour_q, colour_d;
  logic              plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic              col_rd_q, col_rd_d;
  logic [AW-1:0]     col_addr_q, col_addr_d;

  logic              load_sprite;
  logic [XW:0]       sum_x;
  logic [YW:0]       sum_y;

  // (head + c) mod COLS without a divider: both operands are < COLS.
  function automatic logic [AW-1:0] ring_addr(input logic [AW-1:0] head,
                                              input logic [AW-1:0] c);
    logic [AW:0] sum;
    sum = {1'b0, head} + {1'b0, c};
    if (sum >= (AW+1)'(COLS)) sum = sum - (AW+1)'(COLS);
    return sum[AW-1:0];
  endfunction

  // All outputs are registered, so each branch computes the outputs for the
  // state being entered. Entering PLOT from LATCH reads col_data directly
  // because col_reg is only being loaded on that same edge.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    r_d         = r_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    head_d      = head_q;
    spr_x_d     = spr_x_q;
    spr_y_d     = spr_y_q;
    spr_c_d     = spr_c_q;
    col_reg_d   = col_reg_q;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    plot_d      = 1'b0;
    done_d      = 1'b0;
    col_rd_d    = 1'b0;
    col_addr_d  = col_addr_q;
    load_sprite = 1'b0;
    sum_x       = '0;
    sum_y       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          head_d     = ({1'b0, col_head} >= (AW+1)'(COLS)) ? '0 : col_head;
          spr_x_d    = sprite_x;
          spr_y_d    = sprite_y;
          spr_c_d    = sprite_colour;
          c_d        = '0;
          state_d    = S_FETCH;
          col_rd_d   = 1'b1;
          col_addr_d = ring_addr(head_d, '0);
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        col_reg_d = col_data;
        r_d       = '0;
        state_d   = S_PLOT;
        plot_d    = 1'b1;
        x_d       = XW'(X0) + XW'(c_q);
        y_d       = YW'(Y0);
        colour_d  = col_data[0] ? FG : BG;
      end
      S_PLOT: begin
        if (r_q == RW'(ROWS - 1)) begin
          if (c_q == AW'(COLS - 1)) begin
            state_d     = S_SPRITE;
            sx_d        = '0;
            sy_d        = '0;
            load_sprite = 1'b1;
          end else begin
            c_d        = c_q + 1'b1;
            state_d    = S_FETCH;
            col_rd_d   = 1'b1;
            col_addr_d = ring_addr(head_q, c_d);
          end
        end else begin
          r_d      = r_q + 1'b1;
          plot_d   = 1'b1;
          y_d      = YW'(Y0) + YW'(r_d);
          colour_d = col_reg_q[r_d] ? FG : BG;
        end
      end
      S_SPRITE: begin
        if (sy_q == SYW'(SPR_H - 1)) begin
          sy_d = '0;
          if (sx_q == SXW'(SPR_W - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            sx_d        = sx_q + 1'b1;
            load_sprite = 1'b1;
          end
        end else begin
          sy_d        = sy_q + 1'b1;
          load_sprite = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Sprite sums are one bit wider so a wrap past the screen edge is
    // seen as out of range rather than aliasing onto the playfield.
    if (load_sprite) begin
      sum_x    = {1'b0, spr_x_q} + (XW+1)'(sx_d);
      sum_y    = {1'b0, spr_y_q} + (YW+1)'(sy_d);
      x_d      = sum_x[XW-1:0];
      y_d      = sum_y[YW-1:0];
      colour_d = spr_c_q;
      plot_d   = (sum_x >= (XW+1)'(X0)) && (sum_x < (XW+1)'(X0 + COLS)) &&
                 (sum_y >= (YW+1)'(Y0)) && (sum_y < (YW+1)'(Y0 + ROWS));
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      c_q        <= '0;
      r_q        <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      head_q     <= '0;
      spr_x_q    <= '0;
      spr_y_q    <= '0;
      spr_c_q    <= '0;
      col_reg_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      col_rd_q   <= 1'b0;
      col_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      head_q     <= head_d;
      spr_x_q    <= spr_x_d;
      spr_y_q    <= spr_y_d;
      spr_c_q    <= spr_c_d;
      col_reg_q  <= col_reg_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      col_rd_q   <= col_rd_d;
      col_addr_q <= col_addr_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign plot     = plot_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign col_rd   = col_rd_q;
  assign col_addr = col_addr_q;

endmodule

// File: tb/tb_playfield_renderer.sv
// Bench for playfield_renderer: a reference model expands each frame into the
// expected pixel stream and fetch-address sequence; a negedge monitor pops
// and compares whenever the DUT plots or reads the column RAM.
module tb_playfield_renderer;
  localparam int COLS  = 120;
  localparam int ROWS  = 100;
  localparam int X0    = 20;
  localparam int Y0    = 10;
  localparam int SPR_W = 4;
  localparam int SPR_H = 6;
  localparam int FRAME = COLS * (ROWS + 2) + SPR_W * SPR_H + 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic [6:0]      col_head = '0;
  logic [7:0]      sprite_x = '0;
  logic [6:0]      sprite_y = '0;
  logic [2:0]      sprite_colour = '0;
  logic            col_rd;
  logic [6:0]      col_addr;
  logic [ROWS-1:0] col_data;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [2:0]      colour;
  logic            plot, busy, done;

  logic [ROWS-1:0] mem [COLS];

  playfield_renderer #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
                       .SPR_W(SPR_W), .SPR_H(SPR_H)) dut (
    .clk(clk), .resetn(resetn), .start(start), .col_head(col_head),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_colour(sprite_colour),
    .col_rd(col_rd), .col_addr(col_addr), .col_data(col_data),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous column RAM: data one cycle after the read strobe.
  always @(posedge clk) if (col_rd) col_data <= mem[col_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0, t0 = 0;
  bit mon_en = 1'b0, done_seen = 1'b0;
  logic [31:0] pix_q[$];
  logic [31:0] addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (frame cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  function automatic logic [31:0] pack(input int px, input int py, input int pc);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [2:0] cc;
    xx = px[7:0];
    yy = py[6:0];
    cc = pc[2:0];
    return {14'b0, xx, yy, cc};
  endfunction

  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (plot) begin
        e = (pix_q.size() != 0) ? pix_q.pop_front() : 32'hDEAD_BEEF;
        chk("pixel", {14'b0, x, y, colour}, e);
      end
      if (col_rd) begin
        e = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
        chk("fetch_addr", {25'b0, col_addr}, e);
      end
      if (done) begin
        chk("done_cycle", cyc - t0, FRAME);
        done_seen = 1'b1;
      end
    end
  end

  // Reference: columns in ring order from the (clamped) head, each top to
  // bottom, then sprite pixels column-major, keeping only on-playfield ones.
  task automatic expect_frame(input int head, input int sx, input int sy, input int sc);
    int h;
    h = (head >= COLS) ? 0 : head;
    pix_q.delete();
    addr_q.delete();
    for (int c = 0; c < COLS; c++) begin
      int a;
      a = (h + c) % COLS;
      addr_q.push_back(a);
      for (int r = 0; r < ROWS; r++)
        pix_q.push_back(pack(X0 + c, Y0 + r, mem[a][r] ? 7 : 0));
    end
    for (int i = 0; i < SPR_W; i++)
      for (int j = 0; j < SPR_H; j++) begin
        int px, py;
        px = sx + i;
        py = sy + j;
        if (px >= X0 && px < X0 + COLS && py >= Y0 && py < Y0 + ROWS)
          pix_q.push_back(pack(px, py, sc));
      end
  endtask

  task automatic wait_to(input int k);
    while (cyc - t0 < k) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) mem[c][r] = 1'($urandom);
  endtask

  task automatic launch(input int head, input int sx, input int sy, input int sc);
    expect_frame(head, sx, sy, sc);
    col_head = 7'(head);
    sprite_x = 8'(sx);
    sprite_y = 7'(sy);
    sprite_colour = 3'(sc);
    start = 1'b1;
    t0 = cyc;
    done_seen = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Latched inputs must not follow these mid-frame changes.
    col_head = 7'($urandom);
    sprite_x = 8'($urandom);
    sprite_y = 7'($urandom);
    sprite_colour = 3'($urandom);
  endtask

  task automatic run_frame(input int head, input int sx, input int sy, input int sc,
                           input bit b2b, input bit probe);
    if (!b2b) @(negedge clk);
    launch(head, sx, sy, sc);
    wait_to(FRAME);
    if (probe) start = 1'b1;   // start during DONE must be ignored
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", {31'b0, busy}, 0);
    chk("done_seen", {31'b0, done_seen}, 1);
    chk("pixels_left", pix_q.size(), 0);
    chk("fetches_left", addr_q.size(), 0);
    if (probe) begin
      @(negedge clk);
      chk("busy_idle_after_probe", {31'b0, busy}, 0);
    end
  endtask

  initial begin
    // Reset held with start asserted.
    resetn = 1'b0;
    start  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", {24'b0, x}, 0);
    chk("rst_y", {25'b0, y}, 0);
    chk("rst_colour", {29'b0, colour}, 0);
    chk("rst_plot", {31'b0, plot}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_col_rd", {31'b0, col_rd}, 0);
    chk("rst_col_addr", {25'b0, col_addr}, 0);
    resetn = 1'b1;
    start  = 1'b0;

    // Alternating column bits (bit0 set), head 0, sprite inside playfield.
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) mem[c][r] = (r % 2 == 0);
    run_frame(0, 50, 40, 5, 1'b0, 1'b0);

    // Ring wrap from head 118.
    fill_random();
    run_frame(118, 20 + $urandom_range(0, 110), 10 + $urandom_range(0, 90),
              $urandom_range(0, 7), 1'b0, 1'b0);

    // Sprite straddling the bottom-right corner; start pulsed in DONE.
    fill_random();
    run_frame($urandom_range(0, COLS - 1), 138, 107, 4, 1'b0, 1'b1);

    // Abort: extra start while busy, then reset mid-frame.
    fill_random();
    @(negedge clk);
    launch($urandom_range(0, COLS - 1), 60, 60, 3);
    wait_to(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(500);
    resetn = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    chk("abort_plot", {31'b0, plot}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_col_rd", {31'b0, col_rd}, 0);
    resetn = 1'b1;
    pix_q.delete();
    addr_q.delete();

    // Restart after abort.
    fill_random();
    run_frame($urandom_range(0, COLS - 1), $urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 7), 1'b0, 1'b0);

    // Out-of-range head clamps to 0; start on first IDLE cycle after DONE;
    // sprite sums overflow both widths.
    fill_random();
    run_frame(125, 254, 126, $urandom_range(0, 7), 1'b1, 1'b0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
